// File: rtl/stall_ctrl_pkg.sv
// Shared types and constants for the stall/flush controller.
package stall_ctrl_pkg;
    localparam int REG_ADDR_W   = 5;
    localparam int MULT_LAT_DEF = 4;
    localparam int DIV_LAT_DEF  = 12;

    typedef enum logic {
        STALL_IDLE = 1'b0,
        STALL_BUSY = 1'b1
    } stall_state_e;
endpackage

// File: rtl/stall_ctrl_muldiv_busy_counter.sv
// Multiply/divide occupancy tracker: reloadable down-counter plus IDLE/BUSY FSM.
module muldiv_busy_counter
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic muldiv_start_EX,
    input  logic is_div_EX,
    output logic muldiv_busy
);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    stall_state_e      state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [CNT_W-1:0]  load_val;

    assign load_val = is_div_EX ? DIV_LOAD : MULT_LOAD;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STALL_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A new start always reloads, even while a previous operation is counting.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (muldiv_start_EX) begin
            cnt_next   = load_val;
            state_next = (load_val != '0) ? STALL_BUSY : STALL_IDLE;
        end else begin
            if (cnt != '0)
                cnt_next = cnt - CNT_W'(1);
            if (state == STALL_BUSY && cnt == CNT_W'(1))
                state_next = STALL_IDLE;
        end
    end

    // Reset masks the stale BUSY state during the reset cycle itself.
    assign muldiv_busy = (state == STALL_BUSY) && !rst;
endmodule

// File: rtl/stall_ctrl.sv
// Load-use and HI/LO occupancy stall controller for PC, IF/ID and ID/EX.
// Define MULDIV_STALL_EN to track multi-cycle mult/div; otherwise only load-use stalls.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] raddr_1_ID,
    input  logic [REG_ADDR_W-1:0] raddr_2_ID,
    input  logic                  uses_rs_ID,
    input  logic                  uses_rt_ID,
    input  logic                  uses_hilo_ID,
    input  logic                  ReadMem_EX,
    input  logic                  WriteReg_EX,
    input  logic [REG_ADDR_W-1:0] waddr_EX,
    input  logic                  muldiv_start_EX,
    input  logic                  is_div_EX,
    output logic                  hold_PC,
    output logic                  hold_IF_ID,
    output logic                  hold_ID_EX,
    output logic                  flush_ID_EX,
    output logic                  muldiv_busy
);
    logic lu, hl, stall;

    assign lu = ReadMem_EX && WriteReg_EX && (waddr_EX != '0) &&
                ((uses_rs_ID && raddr_1_ID == waddr_EX) ||
                 (uses_rt_ID && raddr_2_ID == waddr_EX));

`ifdef MULDIV_STALL_EN
    muldiv_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_busy (
        .clk             (clk),
        .rst             (rst),
        .muldiv_start_EX (muldiv_start_EX),
        .is_div_EX       (is_div_EX),
        .muldiv_busy     (muldiv_busy)
    );
    assign hl = muldiv_busy && uses_hilo_ID;
`else
    logic unused_muldiv;
    assign unused_muldiv = ^{clk, rst, muldiv_start_EX, is_div_EX, uses_hilo_ID};
    assign muldiv_busy   = 1'b0;
    assign hl            = 1'b0;
`endif

    assign stall       = lu || hl;
    assign hold_PC     = stall;
    assign hold_IF_ID  = stall;
    assign flush_ID_EX = stall;
    // ID/EX is bubbled, never frozen.
    assign hold_ID_EX  = 1'b0;
endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline stall/flush controller that produces the hold and bubble controls consumed by the PC register and the IF/ID and ID/EX pipeline registers. It sits beside the ID stage and compares the instruction being decoded with the instruction occupying EX. It detects load-use hazards and HI/LO multiply/divide occupancy. It freezes the front of the pipeline and injects NOP bubbles into ID/EX until each hazard clears.

## Interface
Parameters:
- MULT_LAT, default 4: EX-busy cycles for mult/multu, range 1..15.
- DIV_LAT, default 12: EX-busy cycles for div/divu, range 1..15.
- CNT_W, default 4: width of the busy counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- raddr_1_ID  in  `RegAddrWidth  rs of instruction in ID.
- raddr_2_ID  in  `RegAddrWidth  rt of instruction in ID.
- uses_rs_ID  in  1  ID instruction reads rs.
- uses_rt_ID  in  1  ID instruction reads rt.
- uses_hilo_ID  in  1  ID instruction is mfhi/mflo/mthi/mtlo or a mult/div.
- ReadMem_EX  in  1  EX instruction is a load.
- WriteReg_EX  in  1  EX instruction writes the register file.
- waddr_EX  in  `RegAddrWidth  EX destination register, already resolved from rt/rd.
- muldiv_start_EX  in  1  mult/div entered EX this cycle; one-cycle pulse.
- is_div_EX  in  1  qualifies muldiv_start_EX: 1 = div, 0 = mult.
- hold_PC  out  1  PC keeps its value.
- hold_IF_ID  out  1  IF/ID register keeps its value (`is_hold` of IF/ID).
- hold_ID_EX  out  1  `is_hold` of ID/EX; this block always drives it 0, because ID/EX is bubbled rather than frozen.
- flush_ID_EX  out  1  ID/EX loads all-zero (NOP) controls next edge.
- muldiv_busy  out  1  multiply/divide unit still computing.

## Operation
- Load-use hazard `lu`, combinational: ReadMem_EX & WriteReg_EX & waddr_EX != 0 & ((uses_rs_ID & raddr_1_ID == waddr_EX) | (uses_rt_ID & raddr_2_ID == waddr_EX)).
- Busy counter `cnt` (CNT_W bits, reset 0):
  - on muldiv_start_EX, load DIV_LAT-1 if is_div_EX, else MULT_LAT-1;
  - otherwise decrement while nonzero.
  - A start while cnt != 0 reloads (restart wins). A zero-latency result never occurs (LAT ≥ 1).
- State machine, 2 states, reset IDLE:
  - IDLE -> BUSY on muldiv_start_EX with loaded value ≠ 0.
  - BUSY -> IDLE when cnt == 1 and no start.
  - BUSY -> BUSY on a start (reload).
- muldiv_busy = (state == BUSY).
- HI/LO hazard `hl` = muldiv_busy & uses_hilo_ID.
- stall = lu | hl. hold_PC = hold_IF_ID = flush_ID_EX = stall.
- Simultaneous lu and hl: a single stall; the outputs are identical and the stall lasts until both clear.
- rst forces cnt = 0 and IDLE. All outputs are 0 while rst is high and in the first cycle after it, unless the inputs form a load-use hazard in that cycle.

## Timing
- lu and hl to the outputs: purely combinational, same cycle, no registered latency.
- A load-use stall lasts exactly 1 cycle: the bubble moves the load out of EX.
- For a mult starting in EX at cycle T, muldiv_busy is high T+1..T+MULT_LAT-1. A dependent mfhi in ID is released in cycle T+MULT_LAT.
- With MULT_LAT = 1, no busy cycle occurs and the FSM stays IDLE.
- Reset applied mid-BUSY: the counter clears on that edge and the stall drops the next cycle.

## Configuration
- MULDIV_STALL_EN defined: busy counter, FSM, hl, and muldiv_busy are as above.
- MULDIV_STALL_EN undefined: counter and FSM are removed, muldiv_busy is tied to 0, and stall = lu. Use this for single-cycle multiply builds. muldiv_start_EX and is_div_EX are ignored.

## Structure
- The shared define header holds `RegAddrWidth, the default MULT_LAT/DIV_LAT constants, and the state encodings (STALL_IDLE = 1'b0, STALL_BUSY = 1'b1).
- Sub-module: muldiv_busy_counter. It contains the load/decrement counter plus the FSM and outputs muldiv_busy. It is instantiated only under MULDIV_STALL_EN.

## Test plan
- Load-use: lw $3 in EX (ReadMem_EX=1, WriteReg_EX=1, waddr_EX=3); add in ID with raddr_1_ID=3, uses_rs_ID=1 -> hold_PC = hold_IF_ID = flush_ID_EX = 1 for exactly 1 cycle.
- $zero and unused operand: waddr_EX=0 with raddr_1_ID=0 -> no stall. raddr_2_ID=3 with uses_rt_ID=0 -> no stall.
- Mult then mfhi: muldiv_start_EX pulse at T with is_div_EX=0, uses_hilo_ID=1 -> stall T+1..T+3, released T+4, muldiv_busy low at T+4.
- Div restart: div start at T, second start at T+5 -> busy stays high through T+16, low at T+17.
- Combined: load-use at T+2 while BUSY -> single stall; flush_ID_EX stays 1 until both lu and hl are 0.
- Reset mid-BUSY: rst=1 at T+3 of a div -> muldiv_busy=0 at T+4, outputs 0.
